// File: rtl/mini_alu_16bit_sub_issue.sv
// Issue/collect lane around the combinational mini_ALU_16bit_SUB: operand FIFO, 3-state issue FSM, registered result port.
// Optional overflow-result counter enabled by defining MINI_ALU_SUB_ERR_CNT_EN.
module mini_alu_16bit_sub_issue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data0,
  input  logic [DATA_W-1:0]          in_data1,
  output logic [DATA_W-1:0]          op_data0,
  output logic [DATA_W-1:0]          op_data1,
  input  logic [DATA_W-1:0]          sub_diff,
  input  logic                       sub_overflow,
  input  logic                       sub_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_diff,
  output logic                       out_overflow,
  output logic                       out_ok,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem0_q [DEPTH];
  logic [DATA_W-1:0]   mem1_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   op0_q, op1_q, diff_q;
  logic                valid_q, ovf_q, ok_q;
  logic                push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  // The FSM is the only consumer: it pops when idle or when the held result is being taken.
  assign pop      = !flush && (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem0_q[wr_ptr_q] <= in_data0;
      mem1_q[wr_ptr_q] <= in_data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op0_q   <= '0;
      op1_q   <= '0;
      valid_q <= 1'b0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            op0_q   <= mem0_q[rd_ptr_q];
            op1_q   <= mem1_q[rd_ptr_q];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          diff_q  <= sub_diff;
          ovf_q   <= sub_overflow;
          ok_q    <= sub_valid;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (pop) begin
              op0_q   <= mem0_q[rd_ptr_q];
              op1_q   <= mem1_q[rd_ptr_q];
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MINI_ALU_SUB_ERR_CNT_EN
  logic [15:0] err_q, err_d;

  // Saturating count of overflow results; flush leaves it alone.
  always_comb begin
    err_d = err_q;
    if (!flush && (state_q == EXEC) && sub_overflow && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'h0000;
`endif

  assign op_data0     = op0_q;
  assign op_data1     = op1_q;
  assign out_valid    = valid_q;
  assign out_diff     = diff_q;
  assign out_overflow = ovf_q;
  assign out_ok       = ok_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_mini_alu_16bit_sub_issue.sv
// Directed bench for mini_alu_16bit_sub_issue with a behavioural stand-in for the 16-bit subtractor.
module tb_mini_alu_16bit_sub_issue;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
`ifdef MINI_ALU_SUB_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data0 = '0, in_data1 = '0;
  logic [DATA_W-1:0] op_data0, op_data1;
  logic [DATA_W-1:0] sub_diff;
  logic              sub_overflow, sub_valid;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_diff;
  logic              out_overflow, out_ok;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]       err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Subtractor stand-in: absolute difference, overflow when minuend < subtrahend.
  assign sub_overflow = (op_data0 < op_data1);
  assign sub_valid    = (op_data0 >= op_data1);
  assign sub_diff     = sub_overflow ? (op_data1 - op_data0) : (op_data0 - op_data1);

  mini_alu_16bit_sub_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1),
    .op_data0(op_data0), .op_data1(op_data1),
    .sub_diff(sub_diff), .sub_overflow(sub_overflow), .sub_valid(sub_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_overflow(out_overflow), .out_ok(out_ok),
    .fifo_count(fifo_count), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_err(input int n);
    return ERR_EN ? 32'(n) : 32'd0;
  endfunction

  logic [15:0] pa [5] = '{16'd100, 16'd5, 16'hFFFF, 16'h0000, 16'h1234};
  logic [15:0] pb [5] = '{16'd1,   16'd7, 16'h0000, 16'hFFFF, 16'h1234};
  logic [15:0] pd [5] = '{16'd99,  16'd2, 16'hFFFF, 16'hFFFF, 16'h0000};
  logic        po [5] = '{1'b0,    1'b1,  1'b0,     1'b1,     1'b0};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_op0", op_data0, 0);
    check("rst_op1", op_data1, 0);
    check("rst_err", err_cnt, 0);

    // 9 - 4: result two edges after accept
    in_valid = 1'b1; in_data0 = 16'h0009; in_data1 = 16'h0004;
    tick();
    in_valid = 1'b0;
    check("a_count1", fifo_count, 1);
    check("a_valid_n1", out_valid, 0);
    tick();
    check("a_valid_n2", out_valid, 0);
    check("a_op0", op_data0, 16'h0009);
    check("a_op1", op_data1, 16'h0004);
    check("a_count0", fifo_count, 0);
    tick();
    check("a_valid", out_valid, 1);
    check("a_diff", out_diff, 16'h0005);
    check("a_ovf", out_overflow, 0);
    check("a_ok", out_ok, 1);
    tick();
    check("a_consumed", out_valid, 0);

    // 3 - 5: overflow
    in_valid = 1'b1; in_data0 = 16'h0003; in_data1 = 16'h0005;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("b_valid", out_valid, 1);
    check("b_diff", out_diff, 16'h0002);
    check("b_ovf", out_overflow, 1);
    check("b_ok", out_ok, 0);
    check("b_err", err_cnt, exp_err(1));
    tick();

    // Backpressure: five pushes, FIFO fills to four after the first pop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_ready%0d", i), in_ready, 1);
      in_valid = 1'b1; in_data0 = pa[i]; in_data1 = pb[i];
      tick();
    end
    check("bp_full_ready", in_ready, 0);
    check("bp_full_count", fifo_count, 4);
    in_data0 = 16'h7777; in_data1 = 16'h1111;
    tick();
    in_valid = 1'b0;
    check("bp_no_push", fifo_count, 4);
    check("bp_hold_valid", out_valid, 1);
    check("bp_r0_diff", out_diff, pd[0]);
    check("bp_r0_ovf", out_overflow, po[0]);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("bp_gap%0d", i), out_valid, 0);
      tick();
      check($sformatf("bp_v%0d", i), out_valid, 1);
      check($sformatf("bp_d%0d", i), out_diff, pd[i]);
      check($sformatf("bp_o%0d", i), out_overflow, po[i]);
      check($sformatf("bp_k%0d", i), out_ok, !po[i]);
    end
    tick();
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_count", fifo_count, 0);
    check("bp_err", err_cnt, exp_err(3));

    // Flush while DONE with two pairs buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data0 = 16'd8; in_data1 = 16'd2;
    tick();
    in_data0 = 16'd1; in_data1 = 16'd2;
    tick();
    in_data0 = 16'd2; in_data1 = 16'd1;
    tick();
    check("fl_pre_count", fifo_count, 2);
    check("fl_pre_valid", out_valid, 1);
    check("fl_pre_diff", out_diff, 16'd6);
    flush = 1'b1; in_data0 = 16'd7; in_data1 = 16'd1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid", out_valid, 0);
    check("fl_count", fifo_count, 0);
    check("fl_ready", in_ready, 1);
    tick();
    tick();
    tick();
    check("fl_dropped_valid", out_valid, 0);
    check("fl_dropped_count", fifo_count, 0);
    check("fl_err_kept", err_cnt, exp_err(3));

    // Asynchronous reset in EXEC
    in_valid = 1'b1; in_data0 = 16'h0010; in_data1 = 16'h0020;
    tick();
    in_valid = 1'b0;
    tick();
    check("r_exec_op0", op_data0, 16'h0010);
    rst = 1'b1;
    #1;
    check("r_async_valid", out_valid, 0);
    check("r_async_op0", op_data0, 0);
    check("r_async_diff", out_diff, 0);
    check("r_async_count", fifo_count, 0);
    check("r_async_err", err_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("r_no_stale", out_valid, 0);
    check("r_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
